wb_write_arbiter: RTL and testbench

WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

---
 rtl/wb_write_arbiter_if.sv | 39 +++
 rtl/wb_write_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if
//    Bundles the functional-unit result handshake and the register-file
//    write-port bus of the write-back arbiter.
//    Ports (by modport):
//       master : drives src_valid/src_index/src_data; observes src_ready,
//                write_ports and stall_count (the functional-unit side).
//       slave  : the arbiter itself, the mirror image of master.
//    write_ports is an array of RegFileWritePort {en, index_in, data_in}.
interface wb_write_arbiter_if #(
   parameter int WORD_SIZE       = 64,
   parameter int NUM_PHYS_REGS   = 128,
   parameter int NUM_SRC         = 4,
   parameter int NUM_WRITE_PORTS = 2
);
   localparam int PW = $clog2(NUM_PHYS_REGS);

   typedef struct packed {
      logic                 en;
      logic [PW-1:0]        index_in;
      logic [WORD_SIZE-1:0] data_in;
   } RegFileWritePort;

   logic [NUM_SRC-1:0]                src_valid;
   logic [NUM_SRC-1:0][PW-1:0]        src_index;
   logic [NUM_SRC-1:0][WORD_SIZE-1:0] src_data;
   logic [NUM_SRC-1:0]                src_ready;
   RegFileWritePort [NUM_WRITE_PORTS-1:0] write_ports;
   logic [31:0]                       stall_count;

   modport master (
      output src_valid, src_index, src_data,
      input  src_ready, write_ports, stall_count
   );

   modport slave (
      input  src_valid, src_index, src_data,
      output src_ready, write_ports, stall_count
   );
endinterface

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//    Collects results from NUM_SRC functional units into small per-source
//    FIFOs and drains them onto NUM_WRITE_PORTS registered register-file
//    write ports. Sources are scanned round-robin from rr_ptr; two grants
//    in one cycle never target the same physical register.
//    Ports:
//       clk : clock, rising edge
//       rst : synchronous, active-high reset
//       bus : wb_write_arbiter_if.slave (source handshake, write ports,
//             saturating stall counter)
module wb_write_arbiter #(
   parameter int WORD_SIZE       = 64,
   parameter int NUM_PHYS_REGS   = 128,
   parameter int NUM_SRC         = 4,
   parameter int NUM_WRITE_PORTS = 2,
   parameter int FIFO_DEPTH      = 2
) (
   input logic               clk,
   input logic               rst,
   wb_write_arbiter_if.slave bus
);
   localparam int PW = $clog2(NUM_PHYS_REGS);
   localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic                 en;
      logic [PW-1:0]        index_in;
      logic [WORD_SIZE-1:0] data_in;
   } wp_t;

   // FIFO storage and bookkeeping
   logic [NUM_SRC-1:0][FIFO_DEPTH-1:0][PW-1:0]        fifo_idx_q, fifo_idx_d;
   logic [NUM_SRC-1:0][FIFO_DEPTH-1:0][WORD_SIZE-1:0] fifo_data_q, fifo_data_d;
   logic [NUM_SRC-1:0][FW-1:0] rd_ptr_q, rd_ptr_d;
   logic [NUM_SRC-1:0][FW-1:0] wr_ptr_q, wr_ptr_d;
   logic [NUM_SRC-1:0][CW-1:0] count_q, count_d;

   // Arbitration state and outputs
   logic [SW-1:0]                 rr_ptr_q, rr_ptr_d;
   logic [31:0]                   stall_count_q, stall_count_d;
   wp_t [NUM_WRITE_PORTS-1:0]     write_ports_q, write_ports_d;

   // Combinational helpers
   logic [NUM_SRC-1:0]                ready_s;
   logic [NUM_SRC-1:0]                push_s;
   logic [NUM_SRC-1:0]                nonempty_s;
   logic [NUM_SRC-1:0]                grant_s;
   logic [NUM_SRC-1:0][PW-1:0]        head_idx_s;
   logic [NUM_SRC-1:0][WORD_SIZE-1:0] head_data_s;
   logic                              stall_s;
   logic                              conflict_s;
   logic [SW-1:0]                     sel_s;
   int                                cand_s;
   int                                n_grant_s;

   // Circular pointer increment that also handles non-power-of-two depths
   function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
      if (p == FW'(FIFO_DEPTH - 1)) begin
         return '0;
      end else begin
         return p + FW'(1);
      end
   endfunction

   // Per-source status: ready uses the registered count only, so a pop in
   // the same cycle never opens a full FIFO
   always_comb begin
      ready_s     = '0;
      nonempty_s  = '0;
      push_s      = '0;
      head_idx_s  = '0;
      head_data_s = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ready_s[i]     = (count_q[i] < CW'(FIFO_DEPTH));
         nonempty_s[i]  = (count_q[i] != '0);
         push_s[i]      = bus.src_valid[i] & ready_s[i];
         head_idx_s[i]  = fifo_idx_q[i][rd_ptr_q[i]];
         head_data_s[i] = fifo_data_q[i][rd_ptr_q[i]];
      end
   end

   // Round-robin scan from rr_ptr; a head whose index matches an earlier
   // grant this cycle stays put and the scan moves on
   always_comb begin
      grant_s       = '0;
      write_ports_d = '0;
      rr_ptr_d      = rr_ptr_q;
      n_grant_s     = 0;
      cand_s        = 0;
      sel_s         = '0;
      conflict_s    = 1'b0;
      for (int j = 0; j < NUM_SRC; j++) begin
         cand_s = int'(rr_ptr_q) + j;
         if (cand_s >= NUM_SRC) begin
            cand_s = cand_s - NUM_SRC;
         end else begin
            cand_s = cand_s;
         end
         sel_s      = cand_s[SW-1:0];
         conflict_s = 1'b0;
         for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
            if ((k < n_grant_s) && (write_ports_d[k].index_in == head_idx_s[sel_s])) begin
               conflict_s = 1'b1;
            end else begin
               conflict_s = conflict_s;
            end
         end
         if (nonempty_s[sel_s] && (n_grant_s < NUM_WRITE_PORTS) && !conflict_s) begin
            grant_s[sel_s] = 1'b1;
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
               if (k == n_grant_s) begin
                  write_ports_d[k].en       = 1'b1;
                  write_ports_d[k].index_in = head_idx_s[sel_s];
                  write_ports_d[k].data_in  = head_data_s[sel_s];
               end else begin
                  write_ports_d[k] = write_ports_d[k];
               end
            end
            if (sel_s == SW'(NUM_SRC - 1)) begin
               rr_ptr_d = '0;
            end else begin
               rr_ptr_d = sel_s + SW'(1);
            end
            n_grant_s = n_grant_s + 1;
         end else begin
            rr_ptr_d = rr_ptr_d;
         end
      end
      stall_s = |(nonempty_s & ~grant_s);
      if (stall_s && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end else begin
         stall_count_d = stall_count_q;
      end
   end

   // FIFO next state: push at the tail, pop granted heads, count tracks both
   always_comb begin
      fifo_idx_d  = fifo_idx_q;
      fifo_data_d = fifo_data_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (push_s[i]) begin
            fifo_idx_d[i][wr_ptr_q[i]]  = bus.src_index[i];
            fifo_data_d[i][wr_ptr_q[i]] = bus.src_data[i];
            wr_ptr_d[i]                 = ptr_inc(wr_ptr_q[i]);
         end else begin
            wr_ptr_d[i] = wr_ptr_q[i];
         end
         if (grant_s[i]) begin
            rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
         end else begin
            rd_ptr_d[i] = rd_ptr_q[i];
         end
         case ({push_s[i], grant_s[i]})
            2'b10:   count_d[i] = count_q[i] + CW'(1);
            2'b01:   count_d[i] = count_q[i] - CW'(1);
            default: count_d[i] = count_q[i];
         endcase
      end
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         rr_ptr_q      <= '0;
         stall_count_q <= '0;
         write_ports_q <= '0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         rr_ptr_q      <= rr_ptr_d;
         stall_count_q <= stall_count_d;
         write_ports_q <= write_ports_d;
      end
   end

   // Payload storage; validity lives in count_q, so no reset is needed here
   always_ff @(posedge clk) begin
      fifo_idx_q  <= fifo_idx_d;
      fifo_data_q <= fifo_data_d;
   end

   assign bus.src_ready   = ready_s;
   assign bus.write_ports = write_ports_q;
   assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter
//    Scoreboard bench for wb_write_arbiter: accepted handshakes are queued
//    per source, every write-port beat must match the head of one queue.
//    Directed sequences cover latency, contention, same-index, backpressure
//    and mid-operation reset; a random phase mixes everything.
module tb_wb_write_arbiter;
   localparam int WS  = 64;
   localparam int NPR = 128;
   localparam int NS  = 4;
   localparam int NWP = 2;
   localparam int FD  = 2;
   localparam int PW  = 7;

   typedef struct packed {
      logic [PW-1:0] idx;
      logic [WS-1:0] data;
   } ent_t;

   logic clk;
   logic rst;
   ent_t exp_q[NS][$];
   int   n_vec;
   int   n_err;
   int   out_cnt;
   logic sb_hit;

   wb_write_arbiter_if #(.WORD_SIZE(WS), .NUM_PHYS_REGS(NPR), .NUM_SRC(NS),
                         .NUM_WRITE_PORTS(NWP)) bus ();

   wb_write_arbiter #(.WORD_SIZE(WS), .NUM_PHYS_REGS(NPR), .NUM_SRC(NS),
                      .NUM_WRITE_PORTS(NWP), .FIFO_DEPTH(FD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sb_total();
      int t = 0;
      for (int i = 0; i < NS; i++) t += exp_q[i].size();
      return t;
   endfunction

   // Record accepted handshakes as expected results; reset discards them
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NS; i++) exp_q[i].delete();
      end else begin
         for (int i = 0; i < NS; i++) begin
            if (bus.src_valid[i] && bus.src_ready[i])
               exp_q[i].push_back('{idx: bus.src_index[i], data: bus.src_data[i]});
         end
      end
   end

   // Every enabled port must equal the oldest pending result of some source
   always @(negedge clk) begin
      for (int k = 0; k < NWP; k++) begin
         if (bus.write_ports[k].en) begin
            sb_hit = 1'b0;
            for (int i = 0; i < NS; i++) begin
               if (!sb_hit && exp_q[i].size() > 0) begin
                  if (exp_q[i][0].idx == bus.write_ports[k].index_in &&
                      exp_q[i][0].data == bus.write_ports[k].data_in) begin
                     sb_hit = 1'b1;
                     void'(exp_q[i].pop_front());
                  end
               end
            end
            out_cnt++;
            check("sb_order", {63'd0, sb_hit}, 64'd1);
         end else begin
            check("idle_port_zero",
                  {63'd0, (bus.write_ports[k].index_in != '0) || (bus.write_ports[k].data_in != '0)},
                  64'd0);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.src_valid = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int c = 0; c < 60; c++) begin
         if (sb_total() == 0) break;
         step();
      end
      check(tag, 64'(sb_total()), 64'd0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_en0"},   {63'd0, bus.write_ports[0].en}, 64'd0);
      check({tag, "_en1"},   {63'd0, bus.write_ports[1].en}, 64'd0);
      check({tag, "_ready"}, 64'(bus.src_ready), 64'hF);
      check({tag, "_stall"}, 64'(bus.stall_count), 64'd0);
   endtask

   // Bound the whole run
   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time budget");
      $fatal(1);
   end

   int   snap;
   logic saw_drop;

   initial begin
      n_vec = 0; n_err = 0; out_cnt = 0;
      rst = 1'b1;
      bus.src_valid = '0;
      bus.src_index = '0;
      bus.src_data  = '0;
      step();
      step();
      check_reset_state("reset");
      rst = 1'b0;

      // Single result from source 2
      bus.src_valid    = 4'b0100;
      bus.src_index[2] = 7'd5;
      bus.src_data[2]  = 64'hABCD;
      step();
      bus.src_valid = '0;
      check("single_not_early", {63'd0, bus.write_ports[0].en}, 64'd0);
      step();
      check("single_en",   {63'd0, bus.write_ports[0].en}, 64'd1);
      check("single_idx",  64'(bus.write_ports[0].index_in), 64'd5);
      check("single_data", bus.write_ports[0].data_in, 64'hABCD);
      check("single_p1",   {63'd0, bus.write_ports[1].en}, 64'd0);
      step();
      check("single_once", {63'd0, bus.write_ports[0].en}, 64'd0);

      // Contention: all four sources at once from rr_ptr = 0
      do_reset();
      bus.src_valid = 4'hF;
      for (int i = 0; i < NS; i++) begin
         bus.src_index[i] = 7'(10 + i);
         bus.src_data[i]  = 64'h1000 + 64'(i);
      end
      step();
      bus.src_valid = '0;
      step();
      check("cont_a_p0", bus.write_ports[0].data_in, 64'h1000);
      check("cont_a_p1", bus.write_ports[1].data_in, 64'h1001);
      step();
      check("cont_b_p0", bus.write_ports[0].data_in, 64'h1002);
      check("cont_b_p1", bus.write_ports[1].data_in, 64'h1003);
      check("cont_stall", 64'(bus.stall_count), 64'd1);
      step();
      check("cont_idle", {62'd0, bus.write_ports[1].en, bus.write_ports[0].en}, 64'd0);

      // Same destination index from two sources
      do_reset();
      bus.src_valid    = 4'b0011;
      bus.src_index[0] = 7'd7;
      bus.src_index[1] = 7'd7;
      bus.src_data[0]  = 64'd1;
      bus.src_data[1]  = 64'd2;
      step();
      bus.src_valid = '0;
      step();
      check("same_a_idx",  64'(bus.write_ports[0].index_in), 64'd7);
      check("same_a_data", bus.write_ports[0].data_in, 64'd1);
      check("same_a_p1",   {63'd0, bus.write_ports[1].en}, 64'd0);
      step();
      check("same_b_en",   {63'd0, bus.write_ports[0].en}, 64'd1);
      check("same_b_idx",  64'(bus.write_ports[0].index_in), 64'd7);
      check("same_b_data", bus.write_ports[0].data_in, 64'd2);

      // Backpressure: everyone pushes every cycle, source 0 must stall
      do_reset();
      saw_drop = 1'b0;
      for (int c = 0; c < 40; c++) begin
         bus.src_valid = 4'hF;
         for (int i = 0; i < NS; i++) begin
            bus.src_index[i] = {2'(i), 5'($urandom_range(0, 31))};
            bus.src_data[i]  = {8'(i), 24'd0, 32'(c)};
         end
         step();
         if (!bus.src_ready[0]) saw_drop = 1'b1;
      end
      bus.src_valid = '0;
      check("bp_ready_drop", {63'd0, saw_drop}, 64'd1);
      drain("bp_drain");
      check("bp_stall_seen", {63'd0, bus.stall_count != 32'd0}, 64'd1);

      // Random traffic
      for (int c = 0; c < 300; c++) begin
         bus.src_valid = 4'($urandom_range(0, 15));
         for (int i = 0; i < NS; i++) begin
            bus.src_index[i] = 7'($urandom_range(0, 127));
            bus.src_data[i]  = {$urandom, $urandom};
         end
         step();
      end
      bus.src_valid = '0;
      drain("rand_drain");

      // Reset in the middle of traffic
      for (int c = 0; c < 3; c++) begin
         bus.src_valid = 4'hF;
         for (int i = 0; i < NS; i++) begin
            bus.src_index[i] = 7'($urandom_range(0, 127));
            bus.src_data[i]  = {$urandom, $urandom};
         end
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.src_valid = '0;
      check_reset_state("midrst");
      snap = out_cnt;
      for (int c = 0; c < 10; c++) step();
      check("midrst_no_stale", 64'(out_cnt - snap), 64'd0);
      check("midrst_sb_empty", 64'(sb_total()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
